// File: rtl/md_ctrl_seq.sv
// md_ctrl_seq: EX-stage multiply/divide sequencer for a MIPS-style pipeline.
// Decodes MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO and runs a 1-bit-per-cycle
// shift-add multiply or restoring divide on magnitudes, fixing signs at the end.
// It owns the HI/LO registers and raises the pipeline stall.
// Optional feature macro: MD_MADD_EN adds MADD/MADDU/MSUB/MSUBU (opcode 6'h1C),
// which accumulate the product into {HI,LO}.
module md_ctrl_seq #(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] HILO_RST = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] md_rdata,
    output logic             done
);

    localparam int unsigned      CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] FN_MFHI     = 6'h10;
    localparam logic [5:0] FN_MTHI     = 6'h11;
    localparam logic [5:0] FN_MFLO     = 6'h12;
    localparam logic [5:0] FN_MTLO     = 6'h13;
    localparam logic [5:0] FN_MULT     = 6'h18;
    localparam logic [5:0] FN_MULTU    = 6'h19;
    localparam logic [5:0] FN_DIV      = 6'h1A;
    localparam logic [5:0] FN_DIVU     = 6'h1B;
`ifdef MD_MADD_EN
    localparam logic [5:0] FN_MADD     = 6'h00;
    localparam logic [5:0] FN_MADDU    = 6'h01;
    localparam logic [5:0] FN_MSUB     = 6'h04;
    localparam logic [5:0] FN_MSUBU    = 6'h05;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // How the finished product lands in {HI,LO}
    typedef enum logic [1:0] {
        ACC_WRITE = 2'd0,
        ACC_ADD   = 2'd1,
        ACC_SUB   = 2'd2
    } acc_mode_e;

    // Two's-complement negate of a WIDTH-bit value
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        neg_w = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Two's-complement negate of a 2*WIDTH-bit value
    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        neg_2w = ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of an operand; unsigned ops pass the raw value through
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic is_signed);
        mag = (is_signed && x[WIDTH-1]) ? neg_w(x) : x;
    endfunction

    state_e             state_q, state_d;
    acc_mode_e          mode_q, mode_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;      // mult: {partial, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opb_q, opb_d;      // multiplicand or divisor magnitude
    logic               div_q, div_d;
    logic               neg_q, neg_d;      // product / quotient must be negated
    logic               rneg_q, rneg_d;    // remainder takes negative dividend sign
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               issue_s, issue_div_s, issue_signed_s;
    acc_mode_e          issue_mode_s;
    logic               mfhi_s, mflo_s, mthi_s, mtlo_s;

    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_nx_s;
    logic [WIDTH:0]     div_rem_sh_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic [2*WIDTH-1:0] div_nx_s;
    logic [2*WIDTH-1:0] iter_nx_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] final_s;

    // Instruction decode of the EX slot
    always_comb begin
        issue_s        = 1'b0;
        issue_div_s    = 1'b0;
        issue_signed_s = 1'b0;
        issue_mode_s   = ACC_WRITE;
        mfhi_s         = 1'b0;
        mflo_s         = 1'b0;
        mthi_s         = 1'b0;
        mtlo_s         = 1'b0;
        if (valid_i && opcode == OP_SPECIAL) begin
            case (func)
                FN_MFHI:  mfhi_s = 1'b1;
                FN_MFLO:  mflo_s = 1'b1;
                FN_MTHI:  mthi_s = 1'b1;
                FN_MTLO:  mtlo_s = 1'b1;
                FN_MULT:  begin issue_s = 1'b1; issue_signed_s = 1'b1; end
                FN_MULTU: issue_s = 1'b1;
                FN_DIV:   begin issue_s = 1'b1; issue_div_s = 1'b1; issue_signed_s = 1'b1; end
                FN_DIVU:  begin issue_s = 1'b1; issue_div_s = 1'b1; end
                default:  issue_s = 1'b0;
            endcase
        end else if (valid_i && opcode == OP_SPECIAL2) begin
`ifdef MD_MADD_EN
            case (func)
                FN_MADD:  begin issue_s = 1'b1; issue_signed_s = 1'b1; issue_mode_s = ACC_ADD; end
                FN_MADDU: begin issue_s = 1'b1; issue_mode_s = ACC_ADD; end
                FN_MSUB:  begin issue_s = 1'b1; issue_signed_s = 1'b1; issue_mode_s = ACC_SUB; end
                FN_MSUBU: begin issue_s = 1'b1; issue_mode_s = ACC_SUB; end
                default:  issue_s = 1'b0;
            endcase
`else
            issue_s = 1'b0;
`endif
        end else begin
            issue_s = 1'b0;
        end
    end

    // One shift-add / restoring-divide step plus the signed result fix-up
    always_comb begin
        mul_sum_s    = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                     + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_nx_s     = {mul_sum_s, acc_q[WIDTH-1:1]};
        div_rem_sh_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff_s   = {1'b0, div_rem_sh_s} - {2'b00, opb_q};
        if (div_diff_s[WIDTH+1]) begin
            div_nx_s = {div_rem_sh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            div_nx_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
        iter_nx_s = div_q ? div_nx_s : mul_nx_s;
        prod_s    = neg_q ? neg_2w(iter_nx_s) : iter_nx_s;
        if (div_q) begin
            final_s = {(rneg_q ? neg_w(iter_nx_s[2*WIDTH-1:WIDTH]) : iter_nx_s[2*WIDTH-1:WIDTH]),
                       (neg_q ? neg_w(iter_nx_s[WIDTH-1:0]) : iter_nx_s[WIDTH-1:0])};
        end else begin
            case (mode_q)
                ACC_ADD: final_s = {hi_q, lo_q} + prod_s;
                ACC_SUB: final_s = {hi_q, lo_q} - prod_s;
                default: final_s = prod_s;
            endcase
        end
    end

    // Sequencer next-state: issue, iterate, write HI/LO, flush abort
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (issue_s) begin
                    div_d  = issue_div_s;
                    mode_d = issue_mode_s;
                    neg_d  = issue_signed_s && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                    rneg_d = issue_signed_s && rs_data[WIDTH-1];
                    cnt_d  = {CW{1'b0}};
                    if (issue_div_s) begin
                        acc_d = {{WIDTH{1'b0}}, mag(rs_data, issue_signed_s)};
                        opb_d = mag(rt_data, issue_signed_s);
                    end else begin
                        acc_d = {{WIDTH{1'b0}}, mag(rt_data, issue_signed_s)};
                        opb_d = mag(rs_data, issue_signed_s);
                    end
                    if (issue_div_s && rt_data == {WIDTH{1'b0}}) begin
                        // Divide by zero finishes immediately with a defined result
                        state_d = ST_DONE;
                        hi_d    = rs_data;
                        lo_d    = {WIDTH{1'b1}};
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (mthi_s) begin
                    hi_d = rs_data;
                end else if (mtlo_s) begin
                    lo_d = rs_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = {CW{1'b0}};
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = {CW{1'b0}};
                    acc_d   = iter_nx_s;
                    hi_d    = final_s[2*WIDTH-1:WIDTH];
                    lo_d    = final_s[WIDTH-1:0];
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    acc_d = iter_nx_s;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Stall: issue cycle and every RUN cycle, dropped at once by flush
    always_comb begin
        stall = 1'b0;
        if (flush) begin
            stall = 1'b0;
        end else if (state_q == ST_RUN) begin
            stall = 1'b1;
        end else if (state_q == ST_IDLE && issue_s) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // MFHI/MFLO read port
    always_comb begin
        md_rdata = {WIDTH{1'b0}};
        if (mfhi_s) begin
            md_rdata = hi_q;
        end else if (mflo_s) begin
            md_rdata = lo_q;
        end else begin
            md_rdata = {WIDTH{1'b0}};
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= ACC_WRITE;
            cnt_q   <= {CW{1'b0}};
            acc_q   <= {(2*WIDTH){1'b0}};
            opb_q   <= {WIDTH{1'b0}};
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= HILO_RST;
            lo_q    <= HILO_RST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
